// File: rtl/wb_pkg.sv
// Shared types for the register-file write-port arbiter: FSM states, the
// buffered MDU result entry and the hard-wired zero register index.
package wb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        FORCE = 2'd2
    } wb_state_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } mdu_entry_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_result_fifo.sv
// Small circular buffer for MDU results; one push and one pop per cycle.
// The head is read straight from storage, so an entry is visible only after its push edge.
module wb_result_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  mdu_entry_t    push_entry,
    input  logic          pop,
    output mdu_entry_t    head,
    output logic [CW-1:0] count
);

    mdu_entry_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Storage has no reset; count and pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the writeback stage and buffered
// MDU results, stealing the port with a WB stall once a result has waited too long.
//
// state | meaning
// IDLE  | result buffer empty
// WAIT  | head entry present, pipeline has priority, wait_cnt ages the head
// FORCE | head has waited MAX_WAIT cycles; drain it now and stall WB
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int MAX_WAIT   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        reg_write_WB,
    input  logic [4:0]  rd_WB,
    input  logic [31:0] write_data_WB,
    output logic        stall_WB,
    input  logic        mdu_issue,
    input  logic [4:0]  mdu_issue_rd,
    input  logic        mdu_valid,
    input  logic [4:0]  mdu_rd,
    input  logic [31:0] mdu_data,
    output logic        mdu_ready,
    output logic [31:0] rd_busy,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int WW = $clog2(MAX_WAIT + 1);

    wb_state_t     state, state_nxt;
    logic [WW-1:0] wait_cnt, wait_nxt;
    logic [CW-1:0] count;
    mdu_entry_t    head;
    logic [31:0]   busy_nxt;
    logic          pipe_req, accept, drain, last_entry;

    assign pipe_req   = reg_write_WB && (rd_WB != REG_ZERO);
    assign mdu_ready  = (count != CW'(FIFO_DEPTH));
    assign accept     = mdu_valid && mdu_ready;
    assign last_entry = (count == CW'(1));

    wb_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (accept),
        .push_entry('{rd: mdu_rd, data: mdu_data}),
        .pop       (drain),
        .head      (head),
        .count     (count)
    );

    always_comb begin
        stall_WB = 1'b0;
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        drain    = 1'b0;
        if (!rst) begin
            if (state == FORCE) begin
                drain    = 1'b1;
                stall_WB = 1'b1;
            end else if (pipe_req) begin
                rf_we    = 1'b1;
                rf_waddr = rd_WB;
                rf_wdata = write_data_WB;
            end else if (count != '0) begin
                drain = 1'b1;
            end
            // A drained x0 result is simply discarded.
            if (drain && head.rd != REG_ZERO) begin
                rf_we    = 1'b1;
                rf_waddr = head.rd;
                rf_wdata = head.data;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = WAIT;
                    wait_nxt  = '0;
                end
            end
            WAIT: begin
                if (drain) begin
                    wait_nxt = '0;
                    if (last_entry && !accept) begin
                        state_nxt = IDLE;
                    end
                end else if (wait_cnt == WW'(MAX_WAIT - 1)) begin
                    state_nxt = FORCE;
                end else begin
                    wait_nxt = wait_cnt + WW'(1);
                end
            end
            FORCE: begin
                wait_nxt  = '0;
                state_nxt = (last_entry && !accept) ? IDLE : WAIT;
            end
            default: begin
                state_nxt = IDLE;
                wait_nxt  = '0;
            end
        endcase
    end

    // Issue is applied after the drain clear so a same-register set wins.
    always_comb begin
        busy_nxt = rd_busy;
        if (drain) begin
            busy_nxt[head.rd] = 1'b0;
        end
        if (mdu_issue && mdu_issue_rd != REG_ZERO) begin
            busy_nxt[mdu_issue_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
            rd_busy  <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            rd_busy  <= busy_nxt;
        end
    end

    // Re-issuing to a busy register is only legal when that result drains this cycle.
    always_ff @(posedge clk) begin
        if (!rst && mdu_issue && mdu_issue_rd != REG_ZERO) begin
            a_issue_busy: assert (!rd_busy[mdu_issue_rd] || (drain && head.rd == mdu_issue_rd));
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios plus a randomized
// run compared against a queue-based model of the port-sharing rules.
module tb_wb_port_arbiter;
    import wb_pkg::*;

    localparam int DEPTH = 2;
    localparam int MAXW  = 4;

    logic        clk, rst;
    logic        reg_write_WB;
    logic [4:0]  rd_WB;
    logic [31:0] write_data_WB;
    logic        stall_WB;
    logic        mdu_issue;
    logic [4:0]  mdu_issue_rd;
    logic        mdu_valid;
    logic [4:0]  mdu_rd;
    logic [31:0] mdu_data;
    logic        mdu_ready;
    logic [31:0] rd_busy;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int n_cmp  = 0;
    int n_fail = 0;

    wb_port_arbiter #(.FIFO_DEPTH(DEPTH), .MAX_WAIT(MAXW)) dut (
        .clk          (clk),
        .rst          (rst),
        .reg_write_WB (reg_write_WB),
        .rd_WB        (rd_WB),
        .write_data_WB(write_data_WB),
        .stall_WB     (stall_WB),
        .mdu_issue    (mdu_issue),
        .mdu_issue_rd (mdu_issue_rd),
        .mdu_valid    (mdu_valid),
        .mdu_rd       (mdu_rd),
        .mdu_data     (mdu_data),
        .mdu_ready    (mdu_ready),
        .rd_busy      (rd_busy),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        reg_write_WB = 0; rd_WB = 0; write_data_WB = 0;
        mdu_issue = 0; mdu_issue_rd = 0;
        mdu_valid = 0; mdu_rd = 0; mdu_data = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        clear_inputs();
        reg_write_WB = 1; rd_WB = 5'd3;
        @(negedge clk);
        n_cmp++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_we_during: got %b want 0", rf_we); end
        n_cmp++; if (stall_WB !== 1'b0) begin n_fail++; $display("FAIL reset_stall_during: got %b want 0", stall_WB); end
        tick();
        n_cmp++; if (mdu_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", mdu_ready); end
        n_cmp++; if (rd_busy !== 32'h0) begin n_fail++; $display("FAIL reset_busy: got %h want 0", rd_busy); end
        rst = 0;
        clear_inputs();
        tick();
    endtask

    task automatic test_idle_port();
        mdu_issue = 1; mdu_issue_rd = 5'd5;
        tick();
        mdu_issue = 0;
        mdu_valid = 1; mdu_rd = 5'd5; mdu_data = 32'hDEADBEEF;
        @(negedge clk);
        n_cmp++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL idle_nobypass: got %b want 0", rf_we); end
        n_cmp++; if (rd_busy[5] !== 1'b1) begin n_fail++; $display("FAIL idle_busy_set: got %b want 1", rd_busy[5]); end
        tick();
        mdu_valid = 0;
        @(negedge clk);
        n_cmp++; if ({rf_we, rf_waddr, rf_wdata, stall_WB} !== {1'b1, 5'd5, 32'hDEADBEEF, 1'b0}) begin
            n_fail++; $display("FAIL idle_drain: got we=%b a=%0d d=%h st=%b want we=1 a=5 d=deadbeef st=0", rf_we, rf_waddr, rf_wdata, stall_WB);
        end
        tick();
        n_cmp++; if (rd_busy[5] !== 1'b0) begin n_fail++; $display("FAIL idle_busy_clr: got %b want 0", rd_busy[5]); end
    endtask

    task automatic test_force();
        mdu_issue = 1; mdu_issue_rd = 5'd9;
        tick();
        mdu_issue = 0;
        reg_write_WB = 1; rd_WB = 5'd3; write_data_WB = 32'h33;
        mdu_valid = 1; mdu_rd = 5'd9; mdu_data = 32'h99;
        tick();
        mdu_valid = 0;
        for (int i = 0; i < MAXW; i++) begin
            @(negedge clk);
            n_cmp++; if ({rf_we, rf_waddr, stall_WB} !== {1'b1, 5'd3, 1'b0}) begin
                n_fail++; $display("FAIL force_pipe%0d: got we=%b a=%0d st=%b want we=1 a=3 st=0", i, rf_we, rf_waddr, stall_WB);
            end
            tick();
        end
        @(negedge clk);
        n_cmp++; if ({rf_we, rf_waddr, rf_wdata, stall_WB} !== {1'b1, 5'd9, 32'h99, 1'b1}) begin
            n_fail++; $display("FAIL force_steal: got we=%b a=%0d d=%h st=%b want we=1 a=9 d=99 st=1", rf_we, rf_waddr, rf_wdata, stall_WB);
        end
        tick();
        @(negedge clk);
        n_cmp++; if ({rf_waddr, stall_WB} !== {5'd3, 1'b0}) begin
            n_fail++; $display("FAIL force_resume: got a=%0d st=%b want a=3 st=0", rf_waddr, stall_WB);
        end
        tick();
        clear_inputs();
        n_cmp++; if (rd_busy[9] !== 1'b0) begin n_fail++; $display("FAIL force_busy_clr: got %b want 0", rd_busy[9]); end
    endtask

    task automatic test_full();
        mdu_entry_t got[$];
        bit         first_stall = 1;
        for (int r = 10; r <= 12; r++) begin
            mdu_issue = 1; mdu_issue_rd = 5'(r);
            tick();
        end
        mdu_issue = 0;
        reg_write_WB = 1; rd_WB = 5'd3; write_data_WB = 32'h1;
        mdu_valid = 1; mdu_rd = 5'd10; mdu_data = 32'hA0A0;
        tick();
        mdu_rd = 5'd11; mdu_data = 32'hB1B1;
        @(negedge clk);
        n_cmp++; if (mdu_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_one: got %b want 1", mdu_ready); end
        tick();
        mdu_rd = 5'd12; mdu_data = 32'hC2C2;
        for (int i = 0; i < 60 && got.size() < 3; i++) begin
            @(negedge clk);
            if (i == 0) begin
                n_cmp++; if (mdu_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready_zero: got %b want 0", mdu_ready); end
            end
            if (stall_WB && first_stall) begin
                first_stall = 0;
                n_cmp++; if (mdu_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready_on_drain: got %b want 0", mdu_ready); end
            end
            if (rf_we && rf_waddr != 5'd3) got.push_back('{rd: rf_waddr, data: rf_wdata});
            if (mdu_valid && mdu_ready) begin
                tick();
                mdu_valid = 0;
            end else begin
                tick();
            end
        end
        n_cmp++; if (got.size() != 3) begin n_fail++; $display("FAIL full_drain_count: got %0d want 3", got.size()); end
        else begin
            n_cmp++; if (got[0] !== '{rd: 5'd10, data: 32'hA0A0} || got[1] !== '{rd: 5'd11, data: 32'hB1B1}
                         || got[2] !== '{rd: 5'd12, data: 32'hC2C2}) begin
                n_fail++; $display("FAIL full_order: got %0d/%h %0d/%h %0d/%h want 10/a0a0 11/b1b1 12/c2c2",
                    got[0].rd, got[0].data, got[1].rd, got[1].data, got[2].rd, got[2].data);
            end
        end
        clear_inputs();
        tick();
        n_cmp++; if (rd_busy[12:10] !== 3'b000) begin n_fail++; $display("FAIL full_busy_clr: got %b want 000", rd_busy[12:10]); end
    endtask

    task automatic test_x0();
        reg_write_WB = 1; rd_WB = 5'd3;
        mdu_valid = 1; mdu_rd = 5'd0; mdu_data = 32'hA0;
        tick();
        mdu_data = 32'hA1;
        tick();
        mdu_valid = 0;
        rd_WB = 5'd0;
        @(negedge clk);
        n_cmp++; if (mdu_ready !== 1'b0) begin n_fail++; $display("FAIL x0_full: got %b want 0", mdu_ready); end
        n_cmp++; if ({rf_we, stall_WB} !== 2'b00) begin n_fail++; $display("FAIL x0_drain1: got we=%b st=%b want 0 0", rf_we, stall_WB); end
        tick();
        @(negedge clk);
        n_cmp++; if (mdu_ready !== 1'b1) begin n_fail++; $display("FAIL x0_count_dec: got %b want 1", mdu_ready); end
        n_cmp++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL x0_drain2: got %b want 0", rf_we); end
        tick();
        clear_inputs();
        mdu_issue = 1; mdu_issue_rd = 5'd13;
        tick();
        mdu_issue = 0;
        mdu_valid = 1; mdu_rd = 5'd13; mdu_data = 32'hD13;
        tick();
        mdu_valid = 0;
        reg_write_WB = 1; rd_WB = 5'd0; write_data_WB = 32'hBAD;
        @(negedge clk);
        n_cmp++; if ({rf_we, rf_waddr, rf_wdata, stall_WB} !== {1'b1, 5'd13, 32'hD13, 1'b0}) begin
            n_fail++; $display("FAIL x0_pipe_yield: got we=%b a=%0d d=%h st=%b want we=1 a=13 d=d13 st=0", rf_we, rf_waddr, rf_wdata, stall_WB);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_scoreboard();
        mdu_issue = 1; mdu_issue_rd = 5'd7;
        tick();
        mdu_issue = 0;
        mdu_valid = 1; mdu_rd = 5'd7; mdu_data = 32'h77;
        tick();
        mdu_valid = 0;
        mdu_issue = 1; mdu_issue_rd = 5'd7;
        @(negedge clk);
        n_cmp++; if ({rf_we, rf_waddr} !== {1'b1, 5'd7}) begin n_fail++; $display("FAIL sb_drain: got we=%b a=%0d want we=1 a=7", rf_we, rf_waddr); end
        tick();
        n_cmp++; if (rd_busy[7] !== 1'b1) begin n_fail++; $display("FAIL sb_set_wins: got %b want 1", rd_busy[7]); end
        mdu_issue_rd = 5'd0;
        tick();
        mdu_issue = 0;
        n_cmp++; if (rd_busy !== 32'h0000_0080) begin n_fail++; $display("FAIL sb_issue_x0: got %h want 00000080", rd_busy); end
    endtask

    task automatic test_reset_mid();
        mdu_issue = 1; mdu_issue_rd = 5'd14;
        tick();
        mdu_issue_rd = 5'd15;
        tick();
        mdu_issue = 0;
        reg_write_WB = 1; rd_WB = 5'd3;
        mdu_valid = 1; mdu_rd = 5'd14; mdu_data = 32'hE14;
        tick();
        mdu_rd = 5'd15; mdu_data = 32'hF15;
        tick();
        mdu_valid = 0;
        @(negedge clk);
        n_cmp++; if (mdu_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_full: got %b want 0", mdu_ready); end
        rst = 1;
        @(negedge clk);
        n_cmp++; if ({rf_we, stall_WB} !== 2'b00) begin n_fail++; $display("FAIL rmid_during: got we=%b st=%b want 0 0", rf_we, stall_WB); end
        tick();
        rst = 0;
        clear_inputs();
        for (int i = 0; i < MAXW + 3; i++) begin
            @(negedge clk);
            n_cmp++; if ({rf_we, mdu_ready, rd_busy} !== {1'b0, 1'b1, 32'h0}) begin
                n_fail++; $display("FAIL rmid_after%0d: got we=%b rdy=%b busy=%h want we=0 rdy=1 busy=0", i, rf_we, mdu_ready, rd_busy);
            end
            tick();
        end
    endtask

    task automatic test_random();
        mdu_entry_t  q[$];
        logic [4:0]  pending[$];
        logic [31:0] m_busy = '0;
        int          waited = 0;
        bit          offering = 0;
        bit          forced, pipe, drained, acc;
        logic        e_we, e_st;
        logic [4:0]  e_a;
        logic [31:0] e_d;
        int          r;
        rst = 1; clear_inputs();
        tick();
        rst = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            reg_write_WB  = ($urandom_range(9, 0) < 7);
            rd_WB         = ($urandom_range(7, 0) == 0) ? 5'd0 : 5'($urandom_range(31, 0));
            write_data_WB = $urandom;
            mdu_issue     = ($urandom_range(2, 0) == 0);
            r             = $urandom_range(31, 1);
            mdu_issue_rd  = ($urandom_range(9, 0) == 0 || m_busy[r]) ? 5'd0 : 5'(r);
            if (!offering) begin
                if (pending.size() > 0 && $urandom_range(1, 0) == 1) begin
                    offering = 1; mdu_rd = pending.pop_front(); mdu_data = $urandom;
                end else if ($urandom_range(15, 0) == 0) begin
                    offering = 1; mdu_rd = 5'd0; mdu_data = $urandom;
                end
            end
            mdu_valid = offering;

            forced  = (q.size() != 0) && (waited == MAXW);
            pipe    = reg_write_WB && (rd_WB != 5'd0);
            drained = forced || (!pipe && q.size() != 0);
            e_st    = forced;
            e_we = 0; e_a = 0; e_d = 0;
            if (drained) begin
                if (q[0].rd != 5'd0) begin e_we = 1; e_a = q[0].rd; e_d = q[0].data; end
            end else if (pipe) begin
                e_we = 1; e_a = rd_WB; e_d = write_data_WB;
            end

            @(negedge clk);
            n_cmp++; if ({rf_we, rf_waddr, rf_wdata, stall_WB} !== {e_we, e_a, e_d, e_st}) begin
                n_fail++; $display("FAIL rnd_port c%0d: got we=%b a=%0d d=%h st=%b want we=%b a=%0d d=%h st=%b",
                    cyc, rf_we, rf_waddr, rf_wdata, stall_WB, e_we, e_a, e_d, e_st);
            end
            n_cmp++; if (mdu_ready !== (q.size() != DEPTH)) begin
                n_fail++; $display("FAIL rnd_ready c%0d: got %b want %b", cyc, mdu_ready, q.size() != DEPTH);
            end
            n_cmp++; if (rd_busy !== m_busy) begin
                n_fail++; $display("FAIL rnd_busy c%0d: got %h want %h", cyc, rd_busy, m_busy);
            end

            acc = mdu_valid && (q.size() != DEPTH);
            if (drained) begin
                m_busy[q[0].rd] = 1'b0;
                void'(q.pop_front());
                waited = 0;
            end else if (q.size() != 0) begin
                waited++;
            end
            if (mdu_issue && mdu_issue_rd != 5'd0) begin
                m_busy[mdu_issue_rd] = 1'b1;
                pending.push_back(mdu_issue_rd);
            end
            m_busy[0] = 1'b0;
            if (acc) begin
                q.push_back('{rd: mdu_rd, data: mdu_data});
                offering = 0;
            end
            if (q.size() == 0) waited = 0;
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        rst = 1;
        test_reset();
        test_idle_port();
        test_force();
        test_full();
        test_x0();
        test_scoreboard();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Arbitrates the single register-file write port between the in-order writeback stage and the multi-cycle multiply/divide unit (MDU). Buffers MDU results in a small FIFO, drains them in cycles where the pipeline does not write, and forces a one-cycle writeback stall when an MDU result has waited too long. Also keeps a busy scoreboard of destination registers with an MDU result outstanding, for the hazard unit. Sits between the writeback mux output and the register file.

## Interface
- FIFO_DEPTH, 2, MDU result buffer entries (power of two, ≥2)
- MAX_WAIT, 4, cycles a head entry may wait before a forced drain (≥1)
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- reg_write_WB  in  1  pipeline instruction in WB writes a register
- rd_WB  in  5  pipeline destination register
- write_data_WB  in  32  pipeline result from writeback mux
- stall_WB  out  1  hold WB stage contents this cycle (port stolen)
- mdu_issue  in  1  MDU op issued this cycle
- mdu_issue_rd  in  5  destination of issued op
- mdu_valid  in  1  MDU result offered
- mdu_rd  in  5  result destination
- mdu_data  in  32  result value
- mdu_ready  out  1  FIFO can accept
- rd_busy  out  32  bit i set: MDU result for xi outstanding
- rf_we  out  1  register-file write enable
- rf_waddr  out  5  write address
- rf_wdata  out  32  write data

## Operation
- Pipeline write request: pipe_req = reg_write_WB && rd_WB != 0. Pipeline writes to x0 do not use the port.
- FIFO: accept on mdu_valid && mdu_ready; mdu_ready = (count != FIFO_DEPTH). Accepted entry can drain no earlier than the next cycle (no bypass).
- Port select, each cycle:
  - FORCE state: drain the head; stall_WB=1; pipeline write suppressed.
  - Otherwise, if pipe_req: the pipeline writes and the head waits.
  - Otherwise, if the FIFO is non-empty: drain the head.
- Drained entry with rd=0: consumes the entry with rf_we=0.
- Simultaneous accept and drain: count unchanged. Full FIFO with a drain: mdu_ready stays 0 that cycle, because it is derived from the registered count.
- FSM:
  - IDLE: FIFO empty.
  - WAIT: head present; wait_cnt increments each cycle the head is not drained and clears on any drain.
  - FORCE: one cycle, always drains.
- FSM transitions:
  - IDLE→WAIT on accept.
  - WAIT→FORCE when the head is not drained and wait_cnt == MAX_WAIT-1.
  - WAIT/FORCE→IDLE when the drain empties the FIFO with no accept.
  - Otherwise FORCE→WAIT with wait_cnt=0.
- Scoreboard:
  - mdu_issue with rd≠0 sets the bit.
  - A drain clears the bit of the head rd.
  - Same-register set and clear in one cycle: set wins.
  - Issue to a register whose bit is already set is illegal. Flag it with a simulation assertion; the bit stays set.

## Timing
- rf_we, rf_waddr, rf_wdata and stall_WB are combinational from the current state and inputs: zero-latency pipeline write.
- MDU result latency, acceptance to register file: 1 cycle minimum, MAX_WAIT+1 cycles maximum with the head at the front.
- While rst=1: rf_we=0, stall_WB=0.
- At the first edge with rst=1:
  - FIFO empty, count=0, wait_cnt=0, state IDLE, rd_busy=0.
  - After reset, mdu_ready=1.
- Reset mid-operation discards buffered results and clears rd_busy with no register-file writes.
- rf_waddr/rf_wdata are don't-care when rf_we=0; drive 0.

## Structure
- Shared package wb_pkg holds:
  - the FSM state enum (IDLE, WAIT, FORCE)
  - the mdu_entry_t struct {rd[4:0], data[31:0]}
  - the constant REG_ZERO=5'd0
- One sub-module: wb_result_fifo (parameterised depth, single push/pop, count output). The arbiter FSM, wait counter and scoreboard stay in the top level.

## Test plan
- Idle port: reset, then push MDU {rd=5, data=0xDEADBEEF} with reg_write_WB=0 → next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF, rd_busy[5] clears at that edge.
- Pipeline priority and force: pipe_req every cycle (rd_WB=3), one MDU entry, MAX_WAIT=4 → pipeline writes for 4 cycles, 5th cycle stall_WB=1 with the MDU write; pipeline resumes the next cycle.
- Full FIFO: push 2 entries while the pipeline writes continuously → mdu_ready=0; third offer held until the FIFO has room; all three drain in FIFO order.
- Scoreboard race: mdu_issue rd=7 in the same cycle the head with rd=7 drains → rd_busy[7]=1 afterwards; issue rd=0 → rd_busy unchanged.
- x0 handling: MDU entry with rd=0 drains with rf_we=0 and count decrements; reg_write_WB=1, rd_WB=0 lets a pending MDU entry drain the same cycle.
- Reset mid-operation: 2 entries buffered, state WAIT, rst pulse → count=0, rd_busy=0, no rf_we during or after reset.
